// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Central stall/flush scheduler for the 5-stage pipeline.  Merges the MEM
// data-memory wait handshake, the ID load-use hazard and the ID taken branch
// into per-stage write-enable, bubble and flush controls.  A timeout on the
// data-memory handshake parks the pipeline in a sticky ERROR state that only
// reset can clear.
//
// Build option: define STALL_PERF_EN to build the stall/flush performance
// counters.  When it is undefined the counter ports remain but read 0.

module pipeline_stall_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  input  logic             lu_hazard_i,
  input  logic             branch_taken_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_we_o,
  output logic             idex_bubble_o,
  output logic             exmem_we_o,
  output logic             memwb_we_o,
  output logic             pc_sel_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_t;

  state_t            state_r;
  logic [WAIT_W-1:0] wait_cnt_r;

  logic mem_miss_s;
  logic pc_we_s;
  logic ifid_we_s;
  logic ifid_flush_s;
  logic idex_we_s;
  logic idex_bubble_s;
  logic exmem_we_s;
  logic memwb_we_s;
  logic pc_sel_s;
  logic err_s;

  // A request without a same-cycle ack is a miss; request plus ack is a hit.
  assign mem_miss_s = dmem_req_i & ~dmem_ack_i;

  // Zero-latency control decode from current state and inputs; held at 0 in reset.
  always_comb begin
    pc_we_s       = 1'b0;
    ifid_we_s     = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_we_s     = 1'b0;
    idex_bubble_s = 1'b0;
    exmem_we_s    = 1'b0;
    memwb_we_s    = 1'b0;
    pc_sel_s      = 1'b0;
    err_s         = 1'b0;
    if (!rst_i) begin
      err_s = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_miss_s) begin
            // Whole pipeline frozen; hazards wait for the memory.
            pc_we_s = 1'b0;
          end else if (lu_hazard_i) begin
            // Hold PC and IF/ID, inject a bubble; branch re-resolves next cycle.
            idex_bubble_s = 1'b1;
            idex_we_s     = 1'b1;
            exmem_we_s    = 1'b1;
            memwb_we_s    = 1'b1;
          end else if (branch_taken_i) begin
            pc_we_s      = 1'b1;
            ifid_we_s    = 1'b1;
            idex_we_s    = 1'b1;
            exmem_we_s   = 1'b1;
            memwb_we_s   = 1'b1;
            pc_sel_s     = 1'b1;
            ifid_flush_s = 1'b1;
          end else begin
            pc_we_s    = 1'b1;
            ifid_we_s  = 1'b1;
            idex_we_s  = 1'b1;
            exmem_we_s = 1'b1;
            memwb_we_s = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ack_i) begin
            // Access completes: the whole pipeline advances this cycle.
            pc_we_s    = 1'b1;
            ifid_we_s  = 1'b1;
            idex_we_s  = 1'b1;
            exmem_we_s = 1'b1;
            memwb_we_s = 1'b1;
          end else begin
            pc_we_s = 1'b0;
          end
        end
        ST_ERROR: begin
          err_s = 1'b1;
        end
        default: begin
          // Unreachable encoding is treated as the error state.
          err_s = 1'b1;
        end
      endcase
    end
  end

  assign pc_we_o       = pc_we_s;
  assign ifid_we_o     = ifid_we_s;
  assign ifid_flush_o  = ifid_flush_s;
  assign idex_we_o     = idex_we_s;
  assign idex_bubble_o = idex_bubble_s;
  assign exmem_we_o    = exmem_we_s;
  assign memwb_we_o    = memwb_we_s;
  assign pc_sel_o      = pc_sel_s;
  assign err_o         = err_s;

  // State register and data-memory wait timeout counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_miss_s) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= {WAIT_W{1'b0}};
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          // An ack in the last allowed cycle wins over the timeout.
          if (dmem_ack_i) begin
            state_r <= ST_RUN;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r <= ST_ERROR;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        ST_ERROR: begin
          state_r <= ST_ERROR;
        end
        default: begin
          state_r <= ST_ERROR;
        end
      endcase
    end
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      return value;
    end else begin
      return value + CNT_W'(1);
    end
  endfunction

  // Saturating stall and flush performance counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if ((state_r != ST_ERROR) && !pc_we_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (ifid_flush_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;
`else
  assign stall_cnt_o = {CNT_W{1'b0}};
  assign flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl: directed scenarios plus randomized
// traffic, all checked against a cycle-level behavioural model.
`timescale 1ns/1ps

module tb_pipeline_stall_ctrl;

  localparam int TIMEOUT_CYC = 4;
  localparam int CNT_W       = 5;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: pc_we ifid_we ifid_flush idex_we idex_bubble exmem_we memwb_we pc_sel err
  localparam logic [8:0] O_ZERO   = 9'b000000000;
  localparam logic [8:0] O_ADV    = 9'b110101100;
  localparam logic [8:0] O_LU     = 9'b000111100;
  localparam logic [8:0] O_BRANCH = 9'b111101110;
  localparam logic [8:0] O_ERR    = 9'b000000001;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic dmem_req_i = 1'b0;
  logic dmem_ack_i = 1'b0;
  logic lu_hazard_i = 1'b0;
  logic branch_taken_i = 1'b0;
  logic pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_bubble_o;
  logic exmem_we_o, memwb_we_o, pc_sel_o, err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model state: waiting on memory, how many wait cycles elapsed, dead after timeout.
  bit m_wait = 1'b0;
  int m_age = 0;
  bit m_dead = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_stall_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .lu_hazard_i(lu_hazard_i), .branch_taken_i(branch_taken_i),
    .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .ifid_flush_o(ifid_flush_o),
    .idex_we_o(idex_we_o), .idex_bubble_o(idex_bubble_o),
    .exmem_we_o(exmem_we_o), .memwb_we_o(memwb_we_o),
    .pc_sel_o(pc_sel_o), .err_o(err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [8:0] dut_out();
    return {pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_bubble_o,
            exmem_we_o, memwb_we_o, pc_sel_o, err_o};
  endfunction

  function automatic logic [8:0] model_out();
    if (!rst_i)                           return O_ZERO;
    if (m_dead)                           return O_ERR;
    if (m_wait)                           return dmem_ack_i ? O_ADV : O_ZERO;
    if (dmem_req_i && !dmem_ack_i)        return O_ZERO;
    if (lu_hazard_i)                      return O_LU;
    if (branch_taken_i)                   return O_BRANCH;
    return O_ADV;
  endfunction

  function automatic logic [31:0] exp_cnt(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic model_reset();
    m_wait = 1'b0; m_age = 0; m_dead = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [8:0] e;
    e = model_out();
    if (!rst_i) begin
      model_reset();
    end else begin
      if (!m_dead && !e[8]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (e[6])             m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      if (m_dead) begin
        m_dead = 1'b1;
      end else if (m_wait) begin
        if (dmem_ack_i) begin
          m_wait = 1'b0;
        end else begin
          m_age++;
          if (m_age >= TIMEOUT_CYC) begin
            m_wait = 1'b0;
            m_dead = 1'b1;
          end
        end
      end else if (dmem_req_i && !dmem_ack_i) begin
        m_wait = 1'b1;
        m_age = 0;
      end
    end
  endtask

  // One clock cycle: drive on negedge, compare just after, then clock the model.
  task automatic do_cycle(input string tag, input bit rst, input bit req, input bit ack,
                          input bit lu, input bit br);
    @(negedge clk);
    rst_i = rst; dmem_req_i = req; dmem_ack_i = ack; lu_hazard_i = lu; branch_taken_i = br;
    if (!rst) model_reset();
    #1;
    check_eq({tag, "_out"}, 32'(dut_out()), 32'(model_out()));
    check_eq({tag, "_stall"}, 32'(stall_cnt_o), exp_cnt(m_stall));
    check_eq({tag, "_flush"}, 32'(flush_cnt_o), exp_cnt(m_flush));
    @(posedge clk);
    model_step();
    cyc++;
  endtask

  task automatic reset_pulse();
    do_cycle("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    do_cycle("reset", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk); #1;
    check_eq("reset_zero", 32'(dut_out()), 32'(O_ZERO));

    // Hit: request and ack together
    do_cycle("hit", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("hit_vec", 32'(dut_out()), 32'(O_ADV));
    do_cycle("hit2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("hit_stall_cnt", 32'(stall_cnt_o), 32'd0);

    // Miss with ack 3 cycles after the request cycle
    reset_pulse();
    do_cycle("miss_req", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle("miss_w1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle("miss_w2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle("miss_ack", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("miss_ack_vec", 32'(dut_out()), 32'(O_ADV));
    do_cycle("miss_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("miss_stall_cnt", 32'(stall_cnt_o), PERF ? 32'd3 : 32'd0);

    // Load-use plus branch, then branch alone
    reset_pulse();
    do_cycle("lu_br", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("lu_br_vec", 32'(dut_out()), 32'(O_LU));
    do_cycle("br", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("br_vec", 32'(dut_out()), 32'(O_BRANCH));
    do_cycle("br_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("br_flush_cnt", 32'(flush_cnt_o), PERF ? 32'd1 : 32'd0);

    // Miss with hazards: freeze only, hazards ignored until ack
    reset_pulse();
    do_cycle("mlb_req", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("mlb_freeze", 32'(dut_out()), 32'(O_ZERO));
    do_cycle("mlb_w1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    do_cycle("mlb_ack", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("mlb_ack_vec", 32'(dut_out()), 32'(O_ADV));

    // Timeout without ack, ack later must not clear the error
    reset_pulse();
    do_cycle("to_req", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT_CYC; i++) do_cycle("to_wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle("to_err", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("to_err_vec", 32'(dut_out()), 32'(O_ERR));
    do_cycle("to_err2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("to_err_sticky", 32'(err_o), 32'd1);

    // Ack on the final timeout cycle wins
    reset_pulse();
    do_cycle("tl_req", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) do_cycle("tl_wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle("tl_ack", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    do_cycle("tl_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tl_run_vec", 32'(dut_out()), 32'(O_ADV));

    // Async reset pulse in MEM_WAIT between clock edges
    reset_pulse();
    do_cycle("ar_req", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle("ar_w1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_eq("ar_out_zero", 32'(dut_out()), 32'(O_ZERO));
    check_eq("ar_stall_zero", 32'(stall_cnt_o), 32'd0);
    rst_i = 1'b1; dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
    model_reset();
    #1;
    check_eq("ar_release_vec", 32'(dut_out()), 32'(O_ADV));
    check_eq("ar_release_flush", 32'(flush_cnt_o), 32'd0);
    @(posedge clk);
    model_step();
    cyc++;
    do_cycle("ar_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with varying ack likelihood
    for (int seg = 0; seg < 8; seg++) begin
      reset_pulse();
      for (int i = 0; i < 250; i++) begin
        do_cycle("rnd", ($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < seg * 12),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 35));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
